// File: rtl/cla_adder_pkg.sv
//----------------------------------------------------------------------------
// Package  : cla_adder_pkg
// Purpose  : Shared helpers for the pipelined CLA adder: ceiling division and
//            slice boundary derivation, plus the default CLA group width.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package cla_adder_pkg;

  localparam int GROUP_DEFAULT = 4;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // First bit of slice k.
  function automatic int slice_lo(input int width, input int stages, input int k);
    return k * ceil_div(width, stages);
  endfunction

  // One past the last bit of slice k (the last slice may be narrower).
  function automatic int slice_hi(input int width, input int stages, input int k);
    int hi;
    hi = (k + 1) * ceil_div(width, stages);
    return (hi < width) ? hi : width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_slice_nbit.sv
//----------------------------------------------------------------------------
// Module   : cla_slice_nbit
// Purpose  : Combinational N-bit carry-lookahead slice. Carries inside each
//            GROUP-bit group are computed in sum-of-products lookahead form
//            from the group carry-in; groups ripple into one another.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module cla_slice_nbit
  import cla_adder_pkg::*;
#(
  parameter int N     = 8,
  parameter int GROUP = GROUP_DEFAULT
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int NG = ceil_div(N, GROUP);

  logic [N-1:0] p;
  logic [N-1:0] g;
  logic [N:0]   c;
  logic         cg;
  logic         term;
  logic         prod;

  assign p = a ^ b;
  assign g = a & b;

  // Per-bit carries: lookahead SOP within a group, ripple of group carries.
  always_comb begin
    c    = '0;
    cg   = cin;
    term = cin;
    prod = cin;
    for (int gi = 0; gi < NG; gi++) begin
      c[gi*GROUP] = cg;
      term = cg;
      for (int j = 1; j <= GROUP; j++) begin
        if (gi*GROUP + j <= N) begin
          // carry-in propagated through bits 0..j-1 of the group
          prod = cg;
          for (int t = 0; t < j; t++) begin
            prod = prod & p[gi*GROUP + t];
          end
          term = prod;
          // generate at bit m propagated through bits m+1..j-1
          for (int m = 0; m < j; m++) begin
            prod = g[gi*GROUP + m];
            for (int t = m + 1; t < j; t++) begin
              prod = prod & p[gi*GROUP + t];
            end
            term = term | prod;
          end
          c[gi*GROUP + j] = term;
        end
      end
      cg = term;
    end
  end

  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

`default_nettype wire

// File: rtl/cla_pipe_adder.sv
//----------------------------------------------------------------------------
// Module   : cla_pipe_adder
// Purpose  : Pipelined WIDTH-bit adder/subtractor. Stage k adds slice k with
//            a CLA slice and registers the partial sum, the carry into slice
//            k+1 and the still-unadded upper operand bits. A single global
//            advance signal moves every stage; valid/ready on both sides.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module cla_pipe_adder
  import cla_adder_pkg::*;
#(
  parameter int WIDTH  = 381,
  parameter int STAGES = 3,
  parameter int GROUP  = GROUP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int SW = ceil_div(WIDTH, STAGES);

  // Every slice must hold at least one bit; an empty last slice is rejected.
  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || GROUP < 1 ||
      (STAGES - 1) * SW >= WIDTH) begin : g_bad_params
    $error("cla_pipe_adder: WIDTH/STAGES/GROUP combination leaves an empty slice");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // The whole pipe moves together; it stalls only when the output is held.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Subtraction is A + ~B + 1; the mode is fully absorbed at stage 0.
  assign b_eff = in_sub ? ~in_b : in_b;
  assign c_eff = in_sub ? 1'b1 : in_cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = slice_lo(WIDTH, STAGES, k);
    localparam int HI  = slice_hi(WIDTH, STAGES, k);
    localparam int N   = HI - LO;
    localparam int REM = WIDTH - HI;

    logic [WIDTH-LO-1:0] op_a;
    logic [WIDTH-LO-1:0] op_b;
    logic                op_c;
    logic                valid_d;
    logic [HI-1:0]       sum_d;
    logic [N-1:0]        slice_sum;
    logic                slice_cout;

    logic                valid_q;
    logic [HI-1:0]       sum_q;
    logic                carry_q;

    if (k == 0) begin : g_src_in
      assign op_a    = in_a;
      assign op_b    = b_eff;
      assign op_c    = c_eff;
      assign valid_d = in_valid;
      assign sum_d   = slice_sum;
    end else begin : g_src_prev
      assign op_a    = g_stage[k-1].g_mid.a_q;
      assign op_b    = g_stage[k-1].g_mid.b_q;
      assign op_c    = g_stage[k-1].carry_q;
      assign valid_d = g_stage[k-1].valid_q;
      assign sum_d   = {slice_sum, g_stage[k-1].sum_q};
    end

    cla_slice_nbit #(
      .N     (N),
      .GROUP (GROUP)
    ) u_slice (
      .a    (op_a[N-1:0]),
      .b    (op_b[N-1:0]),
      .cin  (op_c),
      .sum  (slice_sum),
      .cout (slice_cout)
    );

    if (k == STAGES - 1) begin : g_out
      // Output stage: result registers are cleared so reset shows a zero result.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          sum_q   <= '0;
          carry_q <= 1'b0;
        end else if (adv) begin
          valid_q <= valid_d;
          sum_q   <= sum_d;
          carry_q <= slice_cout;
        end
      end
    end else begin : g_mid
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      // Inner stage valid flag; reset discards in-flight beats.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
        end else if (adv) begin
          valid_q <= valid_d;
        end
      end

      // Inner stage data: partial sum, slice carry and skewed upper operands.
      always_ff @(posedge clk) begin
        if (adv) begin
          sum_q   <= sum_d;
          carry_q <= slice_cout;
          a_q     <= op_a[WIDTH-LO-1:N];
          b_q     <= op_b[WIDTH-LO-1:N];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign out_sum   = g_stage[STAGES-1].sum_q;
  assign out_cout  = g_stage[STAGES-1].carry_q;

endmodule

`default_nettype wire
